samp_stream_framer: RTL and testbench

- Consumer end of the sample-queue byte stream (samp_stream_data/count/avail/pull).
- Pulls bursts of queued sample bytes and wraps each burst in a host packet: SYNC, SEQ, LEN, payload, CRC16.
- Emits packets one byte at a time on a valid/ready byte channel toward the host transmit path (USB/UART tx).

---
 rtl/samp_stream_framer.sv | 130 +++++++++++++
 tb/tb_samp_stream_framer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/samp_stream_framer.sv
// Sample-stream packet framer: pulls queued sample bytes in bursts and emits
// SYNC/SEQ/LEN/payload/CRC16 packets one byte at a time on a valid/ready channel.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for enable && avail && count != 0
// SYNC   | presenting SYNC_BYTE
// SEQ    | presenting packet sequence number
// LEN    | presenting latched payload length
// PAY    | passing stream bytes through, one pull per accepted byte
// CRCH   | presenting CRC high byte
// CRCL   | presenting CRC low byte
// GAP    | two dead cycles so the producer's registered avail/count settle
module samp_stream_framer #(
   parameter int          MAX_PAYLOAD = 240,
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [7:0]  samp_stream_data,
   input  logic [9:0]  samp_stream_count,
   input  logic        samp_stream_avail,
   output logic        samp_stream_pull,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic [15:0] pkt_count
);

   localparam logic [9:0] MAX_P  = 10'(MAX_PAYLOAD);
   localparam logic [7:0] MAX_P8 = 8'(MAX_PAYLOAD);

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_SEQ, S_LEN, S_PAY, S_CRCH, S_CRCL, S_GAP
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  seq;
   logic [7:0]  len;
   logic [7:0]  rem;
   logic [15:0] crc;
   logic [15:0] crc_nxt;
   logic        gap_cnt;
   logic        accept;
   logic        start;
   logic [7:0]  len_start;

   // CRC-16/CCITT-FALSE, MSB-first byte update
   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) begin
         r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
      end
      return r;
   endfunction

   assign accept           = tx_valid && tx_ready;
   assign start            = enable && samp_stream_avail && (samp_stream_count != 10'd0);
   assign len_start        = (samp_stream_count > MAX_P) ? MAX_P8 : samp_stream_count[7:0];
   assign samp_stream_pull = (state == S_PAY) && tx_ready;
   assign crc_nxt          = crc_upd(crc, tx_data);

   always_comb begin
      tx_data = SYNC_BYTE;
      case (state)
         S_SEQ:   tx_data = seq;
         S_LEN:   tx_data = len;
         S_PAY:   tx_data = samp_stream_data;
         S_CRCH:  tx_data = crc[15:8];
         S_CRCL:  tx_data = crc[7:0];
         default: tx_data = SYNC_BYTE;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start)  state_nxt = S_SYNC;
         S_SYNC: if (accept) state_nxt = S_SEQ;
         S_SEQ:  if (accept) state_nxt = S_LEN;
         S_LEN:  if (accept) state_nxt = S_PAY;
         S_PAY:  if (accept && rem == 8'd1) state_nxt = S_CRCH;
         S_CRCH: if (accept) state_nxt = S_CRCL;
         S_CRCL: if (accept) state_nxt = S_GAP;
         S_GAP:  if (gap_cnt) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         tx_valid  <= 1'b0;
         busy      <= 1'b0;
         seq       <= 8'd0;
         len       <= 8'd0;
         rem       <= 8'd0;
         crc       <= 16'hFFFF;
         gap_cnt   <= 1'b0;
         pkt_count <= 16'd0;
      end else begin
         state    <= state_nxt;
         tx_valid <= state_nxt inside {S_SYNC, S_SEQ, S_LEN, S_PAY, S_CRCH, S_CRCL};
         busy     <= (state_nxt != S_IDLE);
         case (state)
            S_IDLE: if (start) begin
               len <= len_start;
               rem <= len_start;
               crc <= 16'hFFFF;
            end
            S_SEQ, S_LEN: if (accept) crc <= crc_nxt;
            S_PAY: if (accept) begin
               crc <= crc_nxt;
               rem <= rem - 8'd1;
            end
            S_CRCL: if (accept) begin
               seq       <= seq + 8'd1;
               pkt_count <= pkt_count + 16'd1;
               gap_cnt   <= 1'b0;
            end
            S_GAP: gap_cnt <= ~gap_cnt;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_samp_stream_framer.sv
// Directed bench for samp_stream_framer with a registered sample-queue producer model
// and a posedge monitor capturing accepted bytes and pulls.
module tb_samp_stream_framer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [7:0]  samp_stream_data;
   logic [9:0]  samp_stream_count;
   logic        samp_stream_avail;
   logic        samp_stream_pull;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic [15:0] pkt_count;

   int n_tests = 0;
   int n_fail  = 0;

   samp_stream_framer dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .samp_stream_data(samp_stream_data), .samp_stream_count(samp_stream_count),
      .samp_stream_avail(samp_stream_avail), .samp_stream_pull(samp_stream_pull),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   // producer model: registered count/avail, data is base + bytes already pulled
   logic        prod_load = 1'b0;
   logic [9:0]  prod_ld_total = 10'd0;
   logic [7:0]  prod_base = 8'd0;
   int          p_idx = 0;
   logic [9:0]  p_total = 10'd0;
   logic [9:0]  p_left;

   assign p_left = p_total - 10'(p_idx) - 10'd1;
   assign samp_stream_data = prod_base + 8'(p_idx);

   initial begin
      samp_stream_count = 10'd0;
      samp_stream_avail = 1'b0;
   end

   always @(posedge clk) begin
      if (prod_load) begin
         p_idx             <= 0;
         p_total           <= prod_ld_total;
         samp_stream_count <= prod_ld_total;
         samp_stream_avail <= (prod_ld_total != 10'd0);
      end else if (samp_stream_pull) begin
         p_idx             <= p_idx + 1;
         samp_stream_count <= p_left;
         samp_stream_avail <= (p_left != 10'd0);
      end
   end

   logic [7:0] cap[$];
   int         cap_cyc[$];
   int         pulls = 0;
   int         cyc = 0;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (tx_valid && tx_ready) begin
         cap.push_back(tx_data);
         cap_cyc.push_back(cyc);
      end
      if (samp_stream_pull) pulls = pulls + 1;
   end

   logic [7:0] exp_q[$];

   function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[15] ^ b[i];
         r  = {r[14:0], 1'b0};
         if (fb) r = r ^ 16'h1021;
      end
      return r;
   endfunction

   task automatic make_exp(input logic [7:0] seq, input logic [7:0] len, input logic [7:0] base);
      logic [15:0] c;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(seq);
      exp_q.push_back(len);
      for (int i = 0; i < int'(len); i++) exp_q.push_back(base + 8'(i));
      c = 16'hFFFF;
      for (int i = 1; i < exp_q.size(); i++) c = crc_ref(c, exp_q[i]);
      exp_q.push_back(c[15:8]);
      exp_q.push_back(c[7:0]);
   endtask

   task automatic load_prod(input int total, input logic [7:0] base);
      @(negedge clk);
      prod_ld_total = 10'(total);
      prod_base     = base;
      prod_load     = 1'b1;
      @(negedge clk);
      prod_load     = 1'b0;
   endtask

   task automatic wait_pkt(input logic [15:0] target, input int budget, output bit to);
      to = 1'b1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (pkt_count == target) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
      n_tests++; if (samp_stream_pull !== 1'b0) begin n_fail++; $display("FAIL reset_pull got %b exp 0", samp_stream_pull); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_tests++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL reset_pkt_count got %h exp 0000", pkt_count); end
   endtask

   task automatic test_crc_model();
      logic [7:0]  msg [9];
      logic [15:0] c;
      msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      c = 16'hFFFF;
      for (int i = 0; i < 9; i++) c = crc_ref(c, msg[i]);
      n_tests++; if (c !== 16'h29B1) begin n_fail++; $display("FAIL crc_check got %h exp 29b1", c); end
   endtask

   task automatic test_single();
      int cb, pb;
      bit to;
      enable = 1'b0;
      load_prod(8, 8'h01);
      cb = cap.size(); pb = pulls;
      enable = 1'b1;
      wait_pkt(16'd1, 200, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL single_timeout pkt_count %h exp 0001", pkt_count); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_gap got %b exp 1", busy); end
      @(negedge clk); @(negedge clk);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle got %b exp 0", busy); end
      n_tests++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL single_pkt_count got %h exp 0001", pkt_count); end
      n_tests++; if (pulls - pb != 8) begin n_fail++; $display("FAIL single_pulls got %0d exp 8", pulls - pb); end
      make_exp(8'h00, 8'd8, 8'h01);
      n_tests++;
      if (cap.size() != cb + exp_q.size()) begin
         n_fail++; $display("FAIL single_nbytes got %0d exp %0d", cap.size() - cb, exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (cap[cb+i] !== exp_q[i]) begin n_fail++; $display("FAIL single_byte[%0d] got %h exp %h", i, cap[cb+i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_capping();
      int cb, pb, gap;
      bit to;
      enable = 1'b0;
      load_prod(1020, 8'h10);
      cb = cap.size(); pb = pulls;
      enable = 1'b1;
      wait_pkt(16'd2, 800, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL cap_timeout1 pkt_count %h exp 0002", pkt_count); end
      n_tests++; if (pulls - pb != 240) begin n_fail++; $display("FAIL cap_pulls got %0d exp 240", pulls - pb); end
      make_exp(8'h01, 8'd240, 8'h10);
      n_tests++;
      if (cap.size() < cb + exp_q.size()) begin
         n_fail++; $display("FAIL cap_nbytes got %0d exp %0d", cap.size() - cb, exp_q.size());
      end else begin
         n_tests++; if (cap[cb+2] !== 8'hF0) begin n_fail++; $display("FAIL cap_len got %h exp f0", cap[cb+2]); end
         for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (cap[cb+i] !== exp_q[i]) begin n_fail++; $display("FAIL cap_byte[%0d] got %h exp %h", i, cap[cb+i], exp_q[i]); end
         end
      end
      wait_pkt(16'd3, 800, to);
      enable = 1'b0;
      n_tests++; if (to) begin n_fail++; $display("FAIL cap_timeout2 pkt_count %h exp 0003", pkt_count); end
      make_exp(8'h02, 8'd240, 8'h00);
      n_tests++;
      if (cap.size() < cb + 245 + exp_q.size()) begin
         n_fail++; $display("FAIL cap2_nbytes got %0d exp %0d", cap.size() - cb - 245, exp_q.size());
      end else begin
         gap = cap_cyc[cb+245] - cap_cyc[cb+244];
         n_tests++; if (gap < 4) begin n_fail++; $display("FAIL cap_gap got %0d cycles exp >=4", gap); end
         for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (cap[cb+245+i] !== exp_q[i]) begin n_fail++; $display("FAIL cap2_byte[%0d] got %h exp %h", i, cap[cb+245+i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_back_pressure();
      int cb, pb;
      bit done;
      logic [7:0] prev_d;
      logic prev_stall;
      enable = 1'b0;
      load_prod(12, 8'h40);
      cb = cap.size(); pb = pulls;
      enable = 1'b1;
      done = 1'b0; prev_stall = 1'b0; prev_d = 8'h00;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         tx_ready = ~tx_ready;
         #1;
         if (prev_stall) begin
            n_tests++;
            if (tx_data !== prev_d) begin n_fail++; $display("FAIL bp_hold got %h exp %h", tx_data, prev_d); end
         end
         if (!tx_ready) begin
            n_tests++;
            if (samp_stream_pull !== 1'b0) begin n_fail++; $display("FAIL bp_pull_stall got %b exp 0", samp_stream_pull); end
         end
         prev_stall = tx_valid && !tx_ready;
         prev_d     = tx_data;
         if (pkt_count == 16'd4) done = 1'b1;
      end
      tx_ready = 1'b1;
      n_tests++; if (!done) begin n_fail++; $display("FAIL bp_timeout pkt_count %h exp 0004", pkt_count); end
      n_tests++; if (pulls - pb != 12) begin n_fail++; $display("FAIL bp_pulls got %0d exp 12", pulls - pb); end
      make_exp(8'h03, 8'd12, 8'h40);
      n_tests++;
      if (cap.size() != cb + exp_q.size()) begin
         n_fail++; $display("FAIL bp_nbytes got %0d exp %0d", cap.size() - cb, exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (cap[cb+i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_byte[%0d] got %h exp %h", i, cap[cb+i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_enable_drop();
      int cb, pb;
      bit to;
      load_prod(16, 8'h80);
      cb = cap.size(); pb = pulls;
      enable = 1'b1;
      for (int k = 0; k < 100 && (pulls - pb) < 4; k++) @(negedge clk);
      enable = 1'b0;
      n_tests++; if (pulls - pb != 4) begin n_fail++; $display("FAIL en_mid_pulls got %0d exp 4", pulls - pb); end
      wait_pkt(16'd5, 200, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL en_timeout pkt_count %h exp 0005", pkt_count); end
      n_tests++; if (pulls - pb != 16) begin n_fail++; $display("FAIL en_pulls got %0d exp 16", pulls - pb); end
      make_exp(8'h04, 8'd16, 8'h80);
      n_tests++;
      if (cap.size() != cb + exp_q.size()) begin
         n_fail++; $display("FAIL en_nbytes got %0d exp %0d", cap.size() - cb, exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (cap[cb+i] !== exp_q[i]) begin n_fail++; $display("FAIL en_byte[%0d] got %h exp %h", i, cap[cb+i], exp_q[i]); end
         end
      end
      load_prod(8, 8'h90);
      repeat (20) @(negedge clk);
      n_tests++; if (cap.size() != cb + 21) begin n_fail++; $display("FAIL en_no_start bytes %0d exp 21", cap.size() - cb); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en_busy got %b exp 0", busy); end
   endtask

   task automatic test_reset_mid();
      int cb, pb, cb2, pb2;
      bit to;
      load_prod(16, 8'hC0);
      pb = pulls;
      enable = 1'b1;
      for (int k = 0; k < 100 && (pulls - pb) < 5; k++) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid); end
      n_tests++; if (samp_stream_pull !== 1'b0) begin n_fail++; $display("FAIL rst_pull got %b exp 0", samp_stream_pull); end
      n_tests++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL rst_pkt_count got %h exp 0000", pkt_count); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cb2 = cap.size(); pb2 = pulls;
      n_tests++; if (pb2 - pb != 5) begin n_fail++; $display("FAIL rst_pulls_before got %0d exp 5", pb2 - pb); end
      cb = cb2;
      wait_pkt(16'd1, 200, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL rst_timeout pkt_count %h exp 0001", pkt_count); end
      n_tests++; if (pulls - pb2 != 11) begin n_fail++; $display("FAIL rst_pulls_after got %0d exp 11", pulls - pb2); end
      make_exp(8'h00, 8'd11, 8'hC5);
      n_tests++;
      if (cap.size() != cb + exp_q.size()) begin
         n_fail++; $display("FAIL rst_nbytes got %0d exp %0d", cap.size() - cb, exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (cap[cb+i] !== exp_q[i]) begin n_fail++; $display("FAIL rst_byte[%0d] got %h exp %h", i, cap[cb+i], exp_q[i]); end
         end
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      enable   = 1'b0;
      tx_ready = 1'b1;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_crc_model();
      test_single();
      test_capping();
      test_back_pressure();
      test_enable_drop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
